aim_match_drain: RTL and testbench
==================================

Name: aim_match_drain

Overview:
- Consumer at the output end of the associative index matcher.
- Samples the matcher's per-lane {valid, pos} result vectors on every encode cycle of a job. Keeps the first (lowest-position) match per weight lane.
- After the final iteration, serializes the matched lanes as a stream of (lane, pos) pairs with a valid/ready handshake, lowest lane first, then signals completion.
- Feeds the downstream activation fetch / MAC scheduler.

Parameters:
- LANES, 32, number of weight-channel lanes (matcher width).
- LANE_W, 5, lane index width, equal to clog2(LANES).
- POS_W, 9, match position width (ite*32 + bit index).
- CNT_W, 6, match-count width, equal to clog2(LANES+1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clear  in  1  abort current job and clear capture table (synchronous)
- i_capture  in  1  strobe: i_valid/i_pos are meaningful this cycle (matcher encode cycle)
- i_last  in  1  qualifies i_capture as the final iteration of the job
- i_valid  in  1 x LANES  per-lane match flag from matcher
- i_pos  in  POS_W x LANES  per-lane match position from matcher
- o_busy  out  1  high in S_DRAIN
- o_pair_valid  out  1  pair available
- o_pair_lane  out  LANE_W  lane index of presented pair
- o_pair_pos  out  POS_W  stored position of presented pair
- i_pair_ready  in  1  downstream accepts pair
- o_done  out  1  one-cycle pulse: drain complete
- o_match_cnt  out  CNT_W  number of lanes with a captured match in the current or last job

Behaviour:
- Reset values: state S_COLLECT; hit mask, pending mask and pos table all 0; o_busy=0, o_pair_valid=0, o_pair_lane=0, o_pair_pos=0, o_done=0, o_match_cnt=0.
- Storage: per lane, hit_r (1 bit), pend_r (1 bit) and pos_r (POS_W bits).
- S_COLLECT:
  - If i_clear=1, clear all hit_r/pend_r/pos_r and set o_match_cnt=0. Any i_capture in the same cycle is discarded; clear wins.
  - Else if i_capture=1, then for each lane L with i_valid[L]=1 and hit_r[L]=0: pos_r[L]<=i_pos[L], hit_r[L]<=1, pend_r[L]<=1.
  - A lane already hit is never overwritten; the first iteration wins, giving the lowest position.
  - i_valid/i_pos are don't-care (may be X/Z) when i_capture=0 and must not affect state.
  - If i_capture=1 and i_last=1, the capture above is applied and the next state is S_DRAIN.
  - o_match_cnt is updated registered to popcount(next hit mask) on every capture; it is valid the cycle after capture.
  - i_last without i_capture is ignored.
- S_DRAIN:
  - o_busy=1.
  - o_pair_valid = (pend_r != 0).
  - o_pair_lane = index of the lowest set bit of pend_r; o_pair_pos = pos_r[o_pair_lane]. These are combinational from registers and stable while o_pair_valid=1 and i_pair_ready=0.
  - When o_pair_valid and i_pair_ready are both 1, clear that pend_r bit. The next pair is presented the following cycle, giving a throughput of one pair per cycle with no bubbles.
  - If pend_r == 0 in S_DRAIN, the next state is S_DONE. This includes a zero-match job, which reaches S_DONE one cycle after entering S_DRAIN.
  - i_capture is ignored in S_DRAIN.
  - i_clear in S_DRAIN aborts: clear tables, set o_match_cnt=0, next state S_COLLECT, no o_done pulse. A pair handshake in the same cycle is discarded.
- S_DONE:
  - o_done=1 for exactly one cycle.
  - o_match_cnt holds the job's count.
  - hit_r and pos_r are cleared; the next state is S_COLLECT.
  - o_match_cnt is retained until the next i_clear or the first capture of the next job.
  - i_capture in S_DONE is ignored.
- Latency:
  - Final capture to first o_pair_valid: 1 cycle.
  - Last accept to o_done: 2 cycles (DRAIN sees empty, then DONE).
- Ordering: pairs are emitted in strictly ascending lane order; each hit lane is emitted exactly once per job.
- Widths: i_pos is stored unmodified; no arithmetic on positions. o_match_cnt ranges 0..LANES.
- Asynchronous reset at any time returns all state to the reset values immediately, including during S_DRAIN with a pair presented.

Test Plan:
- Single-iteration job: capture+last with i_valid lanes {3,17,31} and pos {35,4,100}, ready=1 → pairs (3,35),(17,4),(31,100) on consecutive cycles; o_done 2 cycles after the last pair; o_match_cnt=3.
- Multi-iteration first-wins: capture 1 with lane 5 pos 7; capture 2+last with lane 5 pos 39 and lane 6 pos 40 → pairs (5,7),(6,40); o_match_cnt=2.
- Backpressure: 4 matches, i_pair_ready toggled 0,0,1,0,1,1,1 → each pair held stable while ready=0; 4 accepts total; no duplicates or drops.
- Zero matches: capture+last with all i_valid=0 → o_pair_valid never high; o_done 2 cycles after capture; o_match_cnt=0.
- All 32 lanes match with ready=1 → 32 pairs, lanes 0..31, in consecutive cycles; o_match_cnt=32.
- Abort and reset: i_clear mid-drain after 2 of 5 pairs → o_busy=0 next cycle, no o_done, o_match_cnt=0; the next job is unaffected by stale data. Async reset asserted mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/aim_match_drain.sv
// Capture table behind the associative index matcher. It keeps the first match
// per lane over a job, then streams the (lane, pos) pairs out in ascending lane order.
module aim_match_drain #(
  parameter int LANES  = 32,
  parameter int LANE_W = 5,
  parameter int POS_W  = 9,
  parameter int CNT_W  = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_capture,
  input  logic                     i_last,
  input  logic [LANES-1:0]         i_valid,
  input  logic [LANES*POS_W-1:0]   i_pos,
  output logic                     o_busy,
  output logic                     o_pair_valid,
  output logic [LANE_W-1:0]        o_pair_lane,
  output logic [POS_W-1:0]         o_pair_pos,
  input  logic                     i_pair_ready,
  output logic                     o_done,
  output logic [CNT_W-1:0]         o_match_cnt
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] pend_q, pend_d;
  logic [POS_W-1:0] pos_q [LANES];
  logic [POS_W-1:0] pos_d [LANES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] newHit;
  logic [LANE_W-1:0] pairLane;
  logic             pairValid;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Lowest pending lane is the one presented; scanning downward leaves the lowest set bit.
  always_comb begin
    pairLane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) pairLane = LANE_W'(i);
    end
  end

  assign pairValid    = (state_q == S_DRAIN) && (pend_q != '0);
  assign o_busy       = (state_q == S_DRAIN);
  assign o_pair_valid = pairValid;
  assign o_pair_lane  = pairValid ? pairLane : '0;
  assign o_pair_pos   = pairValid ? pos_q[pairLane] : '0;
  assign o_done       = (state_q == S_DONE);
  assign o_match_cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    pend_d  = pend_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    newHit  = '0;
    case (state_q)
      S_COLLECT: begin
        if (i_clear) begin
          hit_d  = '0;
          pend_d = '0;
          for (int l = 0; l < LANES; l++) pos_d[l] = '0;
          cnt_d  = '0;
        end else if (i_capture) begin
          // Only lanes not yet hit accept a position, so earlier iterations win.
          newHit = i_valid & ~hit_q;
          for (int l = 0; l < LANES; l++) begin
            if (newHit[l]) pos_d[l] = i_pos[l*POS_W +: POS_W];
          end
          hit_d  = hit_q | newHit;
          pend_d = pend_q | newHit;
          cnt_d  = popcount(hit_d);
          if (i_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_clear) begin
          hit_d   = '0;
          pend_d  = '0;
          for (int l = 0; l < LANES; l++) pos_d[l] = '0;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end else if (pend_q == '0) begin
          state_d = S_DONE;
        end else if (i_pair_ready) begin
          pend_d[pairLane] = 1'b0;
        end
      end
      S_DONE: begin
        hit_d  = '0;
        pend_d = '0;
        for (int l = 0; l < LANES; l++) pos_d[l] = '0;
        if (i_clear) cnt_d = '0;
        state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_COLLECT;
      hit_q   <= '0;
      pend_q  <= '0;
      pos_q   <= '{default: '0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aim_match_drain.sv
// Directed bench for aim_match_drain: a cycle table for the basic jobs, followed by
// hand-written sequences for backpressure, empty/full jobs, abort and async reset.
module tb_aim_match_drain;

  localparam int LANES = 32;
  localparam int LANE_W = 5;
  localparam int POS_W = 9;
  localparam int CNT_W = 6;
  localparam int PW = LANES * POS_W;

  logic              clk;
  logic              rstN;
  logic              clear;
  logic              capture;
  logic              last;
  logic [LANES-1:0]  valid;
  logic [PW-1:0]     pos;
  logic              busy;
  logic              pairValid;
  logic [LANE_W-1:0] pairLane;
  logic [POS_W-1:0]  pairPos;
  logic              pairReady;
  logic              done;
  logic [CNT_W-1:0]  matchCnt;

  int checkCount = 0;
  int passCount = 0;

  aim_match_drain dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_clear      (clear),
    .i_capture    (capture),
    .i_last       (last),
    .i_valid      (valid),
    .i_pos        (pos),
    .o_busy       (busy),
    .o_pair_valid (pairValid),
    .o_pair_lane  (pairLane),
    .o_pair_pos   (pairPos),
    .i_pair_ready (pairReady),
    .o_done       (done),
    .o_match_cnt  (matchCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             clr;
    logic             cap;
    logic             lst;
    logic [LANES-1:0] vld;
    logic [PW-1:0]    ps;
    logic             rdy;
    logic             eBusy;
    logic             ePv;
    logic [31:0]      eLane;
    logic [31:0]      ePos;
    logic             eDone;
    logic [31:0]      eCnt;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [PW-1:0] putPos(input logic [PW-1:0] flat, input int lane, input int p);
    logic [PW-1:0] r;
    r = flat;
    r[lane*POS_W +: POS_W] = POS_W'(p);
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic clr, input logic cap, input logic lst,
                              input logic [LANES-1:0] vld, input logic [PW-1:0] ps, input logic rdy,
                              input logic eBusy, input logic ePv, input int eLane, input int ePos,
                              input logic eDone, input int eCnt);
    vec_t v;
    v.name = nm; v.clr = clr; v.cap = cap; v.lst = lst; v.vld = vld; v.ps = ps; v.rdy = rdy;
    v.eBusy = eBusy; v.ePv = ePv; v.eLane = eLane; v.ePos = ePos; v.eDone = eDone; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    else passCount++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clear = v.clr; capture = v.cap; last = v.lst;
    valid = v.vld; pos = v.ps; pairReady = v.rdy;
    step();
  endtask

  task automatic checkAll(input string nm, input logic eBusy, input logic ePv, input int eLane,
                          input int ePos, input logic eDone, input int eCnt);
    checkOutput({nm, " busy"}, 32'(busy), 32'(eBusy));
    checkOutput({nm, " pair_valid"}, 32'(pairValid), 32'(ePv));
    checkOutput({nm, " pair_lane"}, 32'(pairLane), eLane);
    checkOutput({nm, " pair_pos"}, 32'(pairPos), ePos);
    checkOutput({nm, " done"}, 32'(done), 32'(eDone));
    checkOutput({nm, " match_cnt"}, 32'(matchCnt), eCnt);
  endtask

  task automatic idleInputs();
    clear = 1'b0; capture = 1'b0; last = 1'b0; valid = 'x; pos = 'x; pairReady = 1'b0;
  endtask

  logic [PW-1:0] p1, p2a, p2b, pw;
  int bpLane[4] = '{1, 8, 9, 20};
  int bpPos[4]  = '{10, 11, 12, 13};
  int bpRdy[7]  = '{0, 0, 1, 0, 1, 1, 1};
  int idx;

  initial begin
    rstN = 1'b0;
    clear = 1'b0; capture = 1'b0; last = 1'b0; valid = '0; pos = '0; pairReady = 1'b0;
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    step();

    p1  = putPos(putPos(putPos('0, 3, 35), 17, 4), 31, 100);
    p2a = putPos('0, 5, 7);
    p2b = putPos(putPos('0, 5, 39), 6, 40);
    vecs[0]  = mk("j1 cap",   0, 1, 1, 32'h8002_0008, p1, 1, 1, 1, 3, 35, 0, 3);
    vecs[1]  = mk("j1 p17",   0, 0, 0, 'x, 'x, 1, 1, 1, 17, 4, 0, 3);
    vecs[2]  = mk("j1 p31",   0, 0, 0, 'x, 'x, 1, 1, 1, 31, 100, 0, 3);
    vecs[3]  = mk("j1 empty", 0, 0, 0, 'x, 'x, 1, 1, 0, 0, 0, 0, 3);
    vecs[4]  = mk("j1 done",  0, 0, 0, 'x, 'x, 1, 0, 0, 0, 0, 1, 3);
    vecs[5]  = mk("j1 idle",  0, 0, 0, 'x, 'x, 0, 0, 0, 0, 0, 0, 3);
    vecs[6]  = mk("j2 cap1",  0, 1, 0, 32'h0000_0020, p2a, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk("j2 cap2",  0, 1, 1, 32'h0000_0060, p2b, 0, 1, 1, 5, 7, 0, 2);
    vecs[8]  = mk("j2 p6",    0, 0, 0, 'x, 'x, 1, 1, 1, 6, 40, 0, 2);
    vecs[9]  = mk("j2 empty", 0, 0, 0, 'x, 'x, 1, 1, 0, 0, 0, 0, 2);
    vecs[10] = mk("j2 done",  0, 0, 0, 'x, 'x, 0, 0, 0, 0, 0, 1, 2);
    vecs[11] = mk("j2 idle",  0, 0, 0, 'x, 'x, 0, 0, 0, 0, 0, 0, 2);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkAll(vecs[i].name, vecs[i].eBusy, vecs[i].ePv, int'(vecs[i].eLane),
               int'(vecs[i].ePos), vecs[i].eDone, int'(vecs[i].eCnt));
    end

    // Backpressure: pair must hold while ready is low.
    pw = '0; valid = '0;
    for (int i = 0; i < 4; i++) begin
      pw = putPos(pw, bpLane[i], bpPos[i]);
      valid[bpLane[i]] = 1'b1;
    end
    clear = 1'b0; capture = 1'b1; last = 1'b1; pos = pw; pairReady = 1'b0;
    step();
    idleInputs();
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      checkAll($sformatf("bp k%0d", k), 1, 1, bpLane[idx], bpPos[idx], 0, 4);
      pairReady = bpRdy[k][0];
      step();
      if (bpRdy[k] != 0) idx++;
    end
    checkAll("bp empty", 1, 0, 0, 0, 0, 4);
    pairReady = 1'b0;
    step();
    checkAll("bp done", 0, 0, 0, 0, 1, 4);
    step();

    // Zero-match job.
    clear = 1'b0; capture = 1'b1; last = 1'b1; valid = '0; pos = '0; pairReady = 1'b1;
    step();
    idleInputs();
    pairReady = 1'b1;
    checkAll("zero drain", 1, 0, 0, 0, 0, 0);
    step();
    checkAll("zero done", 0, 0, 0, 0, 1, 0);
    step();

    // Every lane matches.
    pw = '0;
    for (int l = 0; l < LANES; l++) pw = putPos(pw, l, l * 3 + 1);
    clear = 1'b0; capture = 1'b1; last = 1'b1; valid = '1; pos = pw; pairReady = 1'b1;
    step();
    idleInputs();
    pairReady = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      checkOutput($sformatf("all pv %0d", l), 32'(pairValid), 1);
      checkOutput($sformatf("all lane %0d", l), 32'(pairLane), l);
      checkOutput($sformatf("all pos %0d", l), 32'(pairPos), l * 3 + 1);
      step();
    end
    checkAll("all empty", 1, 0, 0, 0, 0, 32);
    step();
    checkAll("all done", 0, 0, 0, 0, 1, 32);
    step();

    // Abort after two of five pairs, then a fresh job must not see stale lanes.
    pw = '0; valid = '0;
    for (int i = 0; i < 5; i++) begin
      pw = putPos(pw, 2 + 2 * i, 50 + i);
      valid[2 + 2 * i] = 1'b1;
    end
    clear = 1'b0; capture = 1'b1; last = 1'b1; pos = pw; pairReady = 1'b1;
    step();
    idleInputs();
    pairReady = 1'b1;
    checkAll("ab p2", 1, 1, 2, 50, 0, 5);
    step();
    checkAll("ab p4", 1, 1, 4, 51, 0, 5);
    step();
    checkAll("ab p6", 1, 1, 6, 52, 0, 5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checkAll("ab cleared", 0, 0, 0, 0, 0, 0);
    step();
    checkAll("ab no done", 0, 0, 0, 0, 0, 0);
    capture = 1'b1; last = 1'b1; valid = 32'h0000_0080; pos = putPos('0, 7, 77);
    step();
    idleInputs();
    pairReady = 1'b1;
    checkAll("ab new p7", 1, 1, 7, 77, 0, 1);
    step();
    checkAll("ab new empty", 1, 0, 0, 0, 0, 1);
    step();
    checkAll("ab new done", 0, 0, 0, 0, 1, 1);
    step();

    // Async reset while a pair is presented.
    clear = 1'b0; capture = 1'b1; last = 1'b1; valid = 32'h0000_3000;
    pos = putPos(putPos('0, 12, 200), 13, 201); pairReady = 1'b0;
    step();
    idleInputs();
    checkAll("rst pre", 1, 1, 12, 200, 0, 2);
    #2;
    rstN = 1'b0;
    #1;
    checkAll("rst async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    step();
    checkAll("rst after", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
